// File: rtl/mult_seq_ctrl_if.sv
// Handshake and datapath bundle for the sequential multiplier controller.
// slave = controller side, master = producer/consumer/datapath side.
interface mult_seq_ctrl_if #(
    parameter int WL = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [WL-1:0]   in_a;
    logic [WL-1:0]   in_b;
    logic [2*WL-1:0] dp_a;
    logic [WL-1:0]   dp_b;
    logic            dp_load;
    logic            dp_clr;
    logic [2*WL-1:0] dp_product;
    logic            out_valid;
    logic            out_ready;
    logic [2*WL-1:0] out_product;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  dp_product,
        input  out_ready,
        output in_ready,
        output dp_a,
        output dp_b,
        output dp_load,
        output dp_clr,
        output out_valid,
        output out_product
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output dp_product,
        output out_ready,
        input  in_ready,
        input  dp_a,
        input  dp_b,
        input  dp_load,
        input  dp_clr,
        input  out_valid,
        input  out_product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an external shift-add multiplier datapath (WL RUN cycles).
// Define MULT_SEQ_ZERO_SKIP_EN to bypass the datapath for zero operands.
module mult_seq_ctrl #(
    parameter int WL = 4
) (
    input  logic           CLK,
    input  logic           RST,
    mult_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WL) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAP,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [WL-1:0]   r_a;
    logic [WL-1:0]   r_b;
    logic [2*WL-1:0] r_prod;

    logic w_zero;
    logic w_cnt_last;
    logic w_latch;
    logic w_cap;
    logic w_skip;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign w_zero = (bus.in_a == '0) || (bus.in_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_cnt_last = (r_cnt == CW'(WL - 1));

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_cap   = 1'b0;
        w_skip  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_latch = 1'b1;
                    if (w_zero) begin
                        w_skip = 1'b1;
                        w_next = DONE;
                    end else begin
                        w_next = LOAD;
                    end
                end
            end
            LOAD: w_next = RUN;
            RUN: begin
                if (w_cnt_last) begin
                    w_next = CAP;
                end
            end
            CAP: begin
                w_cap  = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else begin
            if (w_latch) begin
                r_a <= bus.in_a;
                r_b <= bus.in_b;
            end
            if (r_state == LOAD) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_cap) begin
                r_prod <= bus.dp_product;
            end else if (w_skip) begin
                r_prod <= '0;
            end
        end
    end

    // dp_clr doubles as the datapath reset, so RST feeds it directly
    assign bus.dp_clr      = RST || (r_state == LOAD);
    assign bus.dp_load     = (r_state == LOAD);
    assign bus.dp_a        = {{WL{1'b0}}, r_a};
    assign bus.dp_b        = r_b;
    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.out_product = r_prod;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed plus randomized bench for mult_seq_ctrl with a shift-add
// datapath model; results compared against plain a*b and fixed latency.
module tb_mult_seq_ctrl;
    localparam int WL = 4;
    localparam int PW = 2 * WL;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mult_seq_ctrl_if #(.WL(WL)) bus ();

    mult_seq_ctrl #(.WL(WL)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // shift-add datapath the controller sequences
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_mc;
    logic [WL-1:0] m_mp;

    always_ff @(posedge CLK) begin
        if (bus.dp_clr) begin
            m_acc <= '0;
            if (bus.dp_load) begin
                m_mc <= bus.dp_a;
                m_mp <= bus.dp_b;
            end else begin
                m_mc <= '0;
                m_mp <= '0;
            end
        end else begin
            if (m_mp[0]) begin
                m_acc <= m_acc + m_mc;
            end
            m_mc <= m_mc << 1;
            m_mp <= m_mp >> 1;
        end
    end

    assign bus.dp_product = m_acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit is_skip(input int a, input int b);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        return (a == 0) || (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // edges after the accept edge until out_valid is seen
    function automatic int ref_lat(input int a, input int b);
        return is_skip(a, b) ? 0 : WL + 2;
    endfunction

    task automatic run_op(input int a, input int b,
                          input int hold, input bit noise);
        int lat;
        int loads;
        lat = 0;
        while (!bus.in_ready && lat < 50) begin
            step();
            lat++;
        end
        check("ready_pre", 64'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_a      = WL'(a);
        bus.in_b      = WL'(b);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("dp_a", 64'(bus.dp_a), 64'(a));
        check("dp_b", 64'(bus.dp_b), 64'(b));
        check("ready_busy", 64'(bus.in_ready), 0);
        lat   = 0;
        loads = 0;
        while (!bus.out_valid && lat < 50) begin
            loads += int'(bus.dp_load);
            if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_a      = WL'($urandom);
                bus.in_b      = WL'($urandom);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 64'(lat), 64'(ref_lat(a, b)));
        check("loads", 64'(loads), is_skip(a, b) ? 0 : 1);
        check("product", 64'(bus.out_product), 64'(a * b));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 64'(bus.out_valid), 1);
            check("hold_prod", 64'(bus.out_product), 64'(a * b));
            check("hold_ready", 64'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("exit_valid", 64'(bus.out_valid), 0);
        check("exit_ready", 64'(bus.in_ready), 1);
    endtask

    initial begin
        int ra;
        int rb;
        int acc1;
        int acc2;
        int exit1;
        int ncyc;
        bit acc_now;
        bit exit_now;
        int results[$];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        RST = 1'b1;
        step();
        step();
        check("rst_ready", 64'(bus.in_ready), 1);
        check("rst_valid", 64'(bus.out_valid), 0);
        check("rst_prod", 64'(bus.out_product), 0);
        check("rst_dp_a", 64'(bus.dp_a), 0);
        check("rst_dp_b", 64'(bus.dp_b), 0);
        check("rst_clr", 64'(bus.dp_clr), 1);
        check("rst_load", 64'(bus.dp_load), 0);

        // reset wins over an offered operand pair
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd5;
        bus.in_b     = 4'd6;
        step();
        check("rst_prio_ready", 64'(bus.in_ready), 1);
        check("rst_prio_dp_a", 64'(bus.dp_a), 0);
        bus.in_valid = 1'b0;
        RST = 1'b0;
        step();
        check("clr_low", 64'(bus.dp_clr), 0);

        run_op(13, 11, 0, 0);
        run_op(15, 15, 5, 0);
        run_op(0, 9, 0, 0);
        run_op(9, 0, 1, 0);

        // abort mid-RUN at cnt=2
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd7;
        bus.in_b     = 4'd5;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        check("abort_run_valid", 64'(bus.out_valid), 0);
        RST = 1'b1;
        #1;
        check("abort_clr", 64'(bus.dp_clr), 1);
        step();
        RST = 1'b0;
        check("abort_ready", 64'(bus.in_ready), 1);
        check("abort_prod", 64'(bus.out_product), 0);
        ncyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ncyc += int'(bus.out_valid);
        end
        check("abort_no_result", 64'(ncyc), 0);
        run_op(3, 6, 0, 0);

        // back-to-back with in_valid held high
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'd2;
        bus.in_b      = 4'd3;
        bus.out_ready = 1'b1;
        acc1  = -1;
        acc2  = -1;
        exit1 = -1;
        for (int c = 0; c < 40 && results.size() < 2; c++) begin
            acc_now  = bus.in_valid && bus.in_ready;
            exit_now = bus.out_valid && bus.out_ready;
            if (exit_now) begin
                results.push_back(int'(bus.out_product));
            end
            step();
            if (acc_now) begin
                if (acc1 < 0) begin
                    acc1     = c;
                    bus.in_a = 4'd4;
                    bus.in_b = 4'd4;
                end else if (acc2 < 0) begin
                    acc2         = c;
                    bus.in_valid = 1'b0;
                end
            end
            if (exit_now && exit1 < 0) begin
                exit1 = c;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_count", 64'(results.size()), 2);
        if (results.size() == 2) begin
            check("b2b_first", 64'(results[0]), 6);
            check("b2b_second", 64'(results[1]), 16);
        end
        check("b2b_gap", 64'(acc2 - exit1), 1);

        for (int n = 0; n < 16; n++) begin
            ra = int'($urandom_range(0, (1 << WL) - 1));
            rb = int'($urandom_range(0, (1 << WL) - 1));
            if (n % 5 == 0) begin
                ra = 0;
            end
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
